rob_commit: RTL
===============

# rob_commit

In-order retirement stage at the tail of the pipeline and the consumer of the reorder buffer that the issue stage fills. Each cycle it inspects up to two ROB entries starting at its head pointer and retires those that are valid, not busy and exception-free. It updates the committed (retirement) register alias table, returns superseded physical registers to the free list, and raises a flush when the oldest entry carries an exception. Macro-ops of at most two uops are retired atomically.

## Interface
- ROB_ENTRIES, 16, ROB depth (power of two)
- NUM_AREGS, 16, architectural registers
- NUM_PREGS, 64, physical registers
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clear  in  1  pipeline clear: head to 0, no commits this cycle, committed RAT kept
- enabled  in  1  commit permitted this cycle
- rob_valid, rob_busy, rob_exception, rob_mstart, rob_mend  in  ROB_ENTRIES each  per-entry flags
- rob_areg  in  ROB_ENTRIES x $clog2(NUM_AREGS)  per-entry destination areg
- rob_preg  in  ROB_ENTRIES x $clog2(NUM_PREGS)  per-entry destination preg
- rob_release  out  ROB_ENTRIES  one-hot/two-hot mask; the ROB owner clears valid on the next edge
- free_valid  out  2  free-list return strobes, slot 0 then slot 1
- free_preg0, free_preg1  out  $clog2(NUM_PREGS)  preg returned per slot
- commit_count  out  2  uops retired this cycle (0..2)
- exc_flush  out  1  one-cycle flush pulse
- head  out  $clog2(ROB_ENTRIES)  oldest unretired entry
- stat_commits, stat_stalls  out  32 each  statistics (see Configuration)

## Operation
- Committed RAT arch[NUM_AREGS] of pregs; reset value 0 for every areg (matches issue-stage RAT reset). Preg 0 is the reserved reset mapping and is never freed.
- States: RUN, FLUSH. Reset/clear enter RUN.
- RUN, enabled, slot 0 = head, slot 1 = (head+1) mod ROB_ENTRIES:
  - e0 ready = valid && !busy && !exception.
  - If head valid && !busy && exception: no retire; go FLUSH.
  - If e0 ready and mend: retire e0; then retire e1 if e1 ready and mstart (a new macro-op that ends in e1, i.e. e1 mend, or a single uop with mstart and mend both set).
  - If e0 ready and !mend: retire e0 and e1 together only if e1 ready and mend; otherwise retire nothing.
  - An exception on e1 never blocks e0; e1 is then handled next cycle at head.
- Per retired uop (areg a, preg p): old = arch[a]; arch[a] <= p; free old unless old == 0 or old == p.
- Two retires to same areg: slot 0 frees arch[a], slot 1 frees p0 (subject to the same suppression); arch[a] ends = p1.
- head <= head + commit_count, wraps modulo ROB_ENTRIES.
- FLUSH (one cycle): exc_flush=1, rob_release all ones, no frees, arch unchanged, head <= 0, back to RUN.
- enabled=0: no retires, state held, FLUSH still completes.

## Timing
- Decision combinational from current-cycle ROB inputs; rob_release, free_*, commit_count, exc_flush registered: valid the cycle after the decision edge, one cycle wide.
- head and arch update on the same edge as the outputs appear; no entry is retired twice despite the ROB owner clearing valid one edge later.
- Reset and clear override everything including FLUSH; all outputs 0, head 0 next cycle; reset also zeroes arch; clear keeps it.
- clear in the same cycle as a retire decision: the retire is dropped.
- Throughput 2 uops/cycle; the exception-to-flush pulse is 1 cycle after detection.

## Configuration
- ROB_COMMIT_STATS_EN defined: stat_commits accumulates commit_count; stat_stalls increments each RUN+enabled cycle with head valid and zero retired; both reset to 0, not affected by clear, wrap at 2^32.
- Undefined: counters not built, stat_* tied to 0.

## Test plan
- Reset, entries 0,1 valid/!busy single-uop, areg 3->preg 5, areg 4->preg 6 -> next cycle commit_count=2, rob_release=0x0003, free_valid=00 (old 0), head=2.
- Then entry 2 areg 3->preg 9 -> free_preg0=5, free_valid=01, arch[3]=9.
- Entry 0 mstart, entry 1 busy+mend -> no retire; clear busy -> both retire same cycle, commit_count=2.
- Head=15, entries 15 and 0 ready -> release=0x8001, head wraps to 1.
- Head entry exception -> next cycle exc_flush=1, release=0xFFFF, no frees; following cycle head=0, arch unchanged.
- Two retires to areg 7 (pregs 10, 11) with arch[7]=8 -> free 8 and 10, arch[7]=11; reset mid-stream -> all outputs 0, head 0, arch zeroed.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: in-order two-wide ROB retirement with committed RAT, free-list returns and exception flush.
// Define ROB_COMMIT_STATS_EN to build the stat_commits/stat_stalls counters.
module rob_commit #(
    parameter int ROB_ENTRIES = 16,
    parameter int NUM_AREGS   = 16,
    parameter int NUM_PREGS   = 64,
    localparam int HW = $clog2(ROB_ENTRIES),
    localparam int AW = $clog2(NUM_AREGS),
    localparam int PW = $clog2(NUM_PREGS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            enabled,
    input  logic [ROB_ENTRIES-1:0]          rob_valid,
    input  logic [ROB_ENTRIES-1:0]          rob_busy,
    input  logic [ROB_ENTRIES-1:0]          rob_exception,
    input  logic [ROB_ENTRIES-1:0]          rob_mstart,
    input  logic [ROB_ENTRIES-1:0]          rob_mend,
    input  logic [ROB_ENTRIES-1:0][AW-1:0]  rob_areg,
    input  logic [ROB_ENTRIES-1:0][PW-1:0]  rob_preg,
    output logic [ROB_ENTRIES-1:0]          rob_release,
    output logic [1:0]                      free_valid,
    output logic [PW-1:0]                   free_preg0,
    output logic [PW-1:0]                   free_preg1,
    output logic [1:0]                      commit_count,
    output logic                            exc_flush,
    output logic [HW-1:0]                   head,
    output logic [31:0]                     stat_commits,
    output logic [31:0]                     stat_stalls
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, nxt_state;
    logic [PW-1:0] arch [NUM_AREGS];
    logic [HW-1:0] h1;
    logic [AW-1:0] a0, a1;
    logic [PW-1:0] p0, p1, old0, old1, nxt_free0, nxt_free1;
    logic rdy0, rdy1, exc0, go, take0, take1, nxt_flush;
    logic [1:0] nxt_free_valid, nxt_count;
    logic [ROB_ENTRIES-1:0] nxt_release;

    always_comb begin
        h1 = head + 1'b1;
        a0 = rob_areg[head];
        a1 = rob_areg[h1];
        p0 = rob_preg[head];
        p1 = rob_preg[h1];
        rdy0 = rob_valid[head] && !rob_busy[head] && !rob_exception[head];
        rdy1 = rob_valid[h1] && !rob_busy[h1] && !rob_exception[h1];
        exc0 = rob_valid[head] && !rob_busy[head] && rob_exception[head];
        go = state == RUN && enabled && !clear;
        // A macro-op split across head and head+1 retires only as a pair.
        take0 = go && rdy0 && (rob_mend[head] || (rdy1 && rob_mend[h1]));
        take1 = go && rdy0 && rdy1 && rob_mend[h1] && (rob_mend[head] ? rob_mstart[h1] : 1'b1);
        old0 = arch[a0];
        old1 = (a1 == a0) ? p0 : arch[a1];
        nxt_free_valid = {take1 && old1 != '0 && old1 != p1, take0 && old0 != '0 && old0 != p0};
        nxt_free0 = nxt_free_valid[0] ? old0 : '0;
        nxt_free1 = nxt_free_valid[1] ? old1 : '0;
        nxt_count = {1'b0, take0} + {1'b0, take1};
        nxt_flush = go && exc0;
        nxt_release = nxt_flush ? '1 :
            (({{(ROB_ENTRIES-1){1'b0}}, take0} << head) | ({{(ROB_ENTRIES-1){1'b0}}, take1} << h1));
        nxt_state = nxt_flush ? FLUSH : RUN;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= RUN;
            head <= '0;
            rob_release <= '0;
            free_valid <= '0;
            free_preg0 <= '0;
            free_preg1 <= '0;
            commit_count <= '0;
            exc_flush <= 1'b0;
            if (reset) arch <= '{default: '0};
        end else begin
            state <= nxt_state;
            head <= (state == FLUSH) ? '0 : head + HW'(nxt_count);
            rob_release <= nxt_release;
            free_valid <= nxt_free_valid;
            free_preg0 <= nxt_free0;
            free_preg1 <= nxt_free1;
            commit_count <= nxt_count;
            exc_flush <= nxt_flush;
            if (take0) arch[a0] <= p0;
            if (take1) arch[a1] <= p1;
        end
    end

`ifdef ROB_COMMIT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_commits <= '0;
            stat_stalls <= '0;
        end else begin
            stat_commits <= stat_commits + 32'(nxt_count);
            stat_stalls <= stat_stalls + 32'(go && rob_valid[head] && nxt_count == '0);
        end
    end
`else
    assign stat_commits = '0;
    assign stat_stalls = '0;
`endif
endmodule
